// File: rtl/ehl_gpio_pkg.sv
// ehl_gpio_pkg: shared op/register codes, arbiter FSM states and the command legality rule.
package ehl_gpio_pkg;
  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_CLR   = 3'd3;
  localparam logic [2:0] OP_INV   = 3'd4;
  localparam logic [3:0] ADR_GDOR = 4'd0;
  localparam logic [3:0] ADR_GOER = 4'd1;
  localparam logic [3:0] ADR_GAFR = 4'd2;
  localparam logic [3:0] ADR_GPER = 4'd3;
  localparam logic [3:0] ADR_GPTR = 4'd4;
  localparam logic [3:0] ADR_GIER = 4'd5;
  localparam logic [3:0] ADR_GISR = 4'd6;
  localparam logic [3:0] ADR_GIFR = 4'd7;
  localparam logic [3:0] ADR_GDIR = 4'd8;
  localparam logic [3:0] ADR_GCMR = 4'd9;
  localparam logic [3:0] ADR_GFMR = 4'd10;
  localparam logic [3:0] ADR_MAX  = 4'd10;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RDWAIT, ST_DONE} state_e;
  // GDIR is read-only; GIFR is write-one-to-clear, so only READ and CLR make sense there.
  function automatic logic cmd_legal(input logic [2:0] op, input logic [3:0] addr);
    return op <= OP_INV && addr <= ADR_MAX && (addr != ADR_GDIR || op == OP_READ) &&
           (addr != ADR_GIFR || op == OP_READ || op == OP_CLR);
  endfunction
endpackage

// File: rtl/ehl_gpio_rr_pick.sv
// ehl_gpio_rr_pick: combinational round-robin picker, first masked request at or after ptr_i.
// Ports: req_i/mask_i request and enable vectors, ptr_i search start; idx_o winner, vld_o any winner.
module ehl_gpio_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         mask_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    vld_o
);
  logic [NREQ-1:0] act;
  assign act = req_i & mask_i;
  assign vld_o = |act;
  // Scan from the farthest offset down so the nearest hit is written last and wins.
  always_comb begin
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (act[(int'(ptr_i) + i) % NREQ]) idx_o = $clog2(NREQ)'((int'(ptr_i) + i) % NREQ);
  end
endmodule

// File: rtl/ehl_gpio_arb.sv
// ehl_gpio_arb: round-robin arbiter serialising NREQ requesters onto one GPIO register command bus.
// Optional bus lock for atomic read-modify-write is built when EHL_GPIO_ARB_LOCK_EN is defined.
// Ports: clk_ug, reset_n (async, active-low); req/req_op/req_addr/req_data[/req_lock] per requester;
//   ack/err/rdata completion back to requesters; cmd_vld/cmd_op/cmd_addr/cmd_data to the decoder;
//   core_rdata read data from the core.
module ehl_gpio_arb
  import ehl_gpio_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
`ifdef EHL_GPIO_ARB_LOCK_EN
  parameter int LOCK_TMO = 255,
`endif
  parameter int RD_LAT = 0
) (
  input  logic                    clk_ug,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [3*NREQ-1:0]       req_op,
  input  logic [4*NREQ-1:0]       req_addr,
  input  logic [WIDTH*NREQ-1:0]   req_data,
`ifdef EHL_GPIO_ARB_LOCK_EN
  input  logic [NREQ-1:0]         req_lock,
`endif
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic [WIDTH-1:0]        rdata,
  output logic                    cmd_vld,
  output logic [2:0]              cmd_op,
  output logic [3:0]              cmd_addr,
  output logic [WIDTH-1:0]        cmd_data,
  input  logic [WIDTH-1:0]        core_rdata
);
  localparam int IW = $clog2(NREQ);
  state_e state_q;
  logic [IW-1:0] ptr_q, win_q, pick;
  logic [NREQ-1:0] mask;
  logic any, legal, rd_wait;
  logic [2:0] pick_op;
  logic [3:0] pick_addr;
  assign pick_op = req_op[3*pick +: 3];
  assign pick_addr = req_addr[4*pick +: 4];
  assign legal = cmd_legal(pick_op, pick_addr);
  assign rd_wait = RD_LAT != 0 && cmd_op == OP_READ;
`ifdef EHL_GPIO_ARB_LOCK_EN
  logic lock_q, locked;
  logic [IW-1:0] hold_q;
  logic [15:0] cnt_q;
  // The lock stops restricting grants once the holder drops req_lock or its idle count saturates.
  assign locked = lock_q && req_lock[hold_q] && cnt_q != 16'(LOCK_TMO);
  assign mask = locked ? NREQ'(1) << hold_q : '1;
  always_ff @(posedge clk_ug or negedge reset_n)
    if (!reset_n) begin
      lock_q <= 1'b0;
      hold_q <= '0;
      cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (locked) cnt_q <= req[hold_q] ? '0 : cnt_q + 1'b1;
      else begin
        lock_q <= any && req_lock[pick];
        hold_q <= pick;
        cnt_q <= '0;
      end
    end
`else
  assign mask = '1;
`endif
  ehl_gpio_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req),
    .mask_i(mask),
    .ptr_i (ptr_q),
    .idx_o (pick),
    .vld_o (any)
  );
  always_ff @(posedge clk_ug or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      win_q <= '0;
      ack <= '0;
      err <= 1'b0;
      rdata <= '0;
      cmd_vld <= 1'b0;
      cmd_op <= '0;
      cmd_addr <= '0;
      cmd_data <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      cmd_vld <= 1'b0;
      case (state_q)
        ST_IDLE: if (any) begin
          win_q <= pick;
          ptr_q <= pick == IW'(NREQ - 1) ? '0 : pick + 1'b1;
          cmd_op <= pick_op;
          cmd_addr <= pick_addr;
          cmd_data <= req_data[WIDTH*pick +: WIDTH];
          cmd_vld <= legal;
          // Rejected commands never reach the decoder and complete one cycle early.
          ack <= legal ? '0 : NREQ'(1) << pick;
          err <= !legal;
          state_q <= legal ? ST_ISSUE : ST_DONE;
        end
        ST_ISSUE: begin
          if (RD_LAT == 0 && cmd_op == OP_READ) rdata <= core_rdata;
          ack <= rd_wait ? '0 : NREQ'(1) << win_q;
          state_q <= rd_wait ? ST_RDWAIT : ST_DONE;
        end
        ST_RDWAIT: begin
          rdata <= core_rdata;
          ack <= NREQ'(1) << win_q;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_ehl_gpio_arb.sv
// tb_ehl_gpio_arb: directed bench for ehl_gpio_arb with a transaction-level model checked every cycle.
module tb_ehl_gpio_arb;
  logic clk_ug = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [11:0] req_op = '0;
  logic [15:0] req_addr = '0;
  logic [127:0] req_data = '0;
`ifdef EHL_GPIO_ARB_LOCK_EN
  logic [3:0] req_lock = '0;
`endif
  logic [31:0] core_rdata = '0;
  logic [3:0] ack_o [2];
  logic err_o [2];
  logic [31:0] rdata_o [2];
  logic vld_o [2];
  logic [2:0] op_o [2];
  logic [3:0] addr_o [2];
  logic [31:0] data_o [2];
  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mdl_en = 1'b1;
  always #5 clk_ug = ~clk_ug;
  // Instance 0 has a combinational core read path, instance 1 a registered one.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ehl_gpio_arb #(
      .NREQ(4),
      .WIDTH(32),
`ifdef EHL_GPIO_ARB_LOCK_EN
      .LOCK_TMO(4),
`endif
      .RD_LAT(g)
    ) u_dut (
      .clk_ug    (clk_ug),
      .reset_n   (reset_n),
      .req       (req),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_data  (req_data),
`ifdef EHL_GPIO_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .ack       (ack_o[g]),
      .err       (err_o[g]),
      .rdata     (rdata_o[g]),
      .cmd_vld   (vld_o[g]),
      .cmd_op    (op_o[g]),
      .cmd_addr  (addr_o[g]),
      .cmd_data  (data_o[g]),
      .core_rdata(core_rdata)
    );
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask
  function automatic bit legal(input logic [2:0] op, input logic [3:0] a);
    if (op > 3'd4 || a > 4'd10) return 1'b0;
    if (a == 4'd8) return op == 3'd0;
    if (a == 4'd7) return op == 3'd0 || op == 3'd3;
    return 1'b1;
  endfunction
  // Model: per instance, the cycle numbers at which the latched command strobes, samples read data and acks.
  int m_ptr [2], m_free [2], m_vld [2], m_ack [2], m_rd [2], m_win [2];
  bit m_err [2];
  logic [2:0] m_op [2];
  logic [3:0] m_addr [2];
  logic [31:0] m_data [2], m_rdata [2];
  initial forever begin
    @(negedge clk_ug);
    cyc++;
    if (mdl_en) for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_ptr[k] = 0; m_free[k] = 0; m_vld[k] = -1; m_ack[k] = -1; m_rd[k] = -1; m_win[k] = 0;
        m_err[k] = 1'b0; m_op[k] = '0; m_addr[k] = '0; m_data[k] = '0; m_rdata[k] = '0;
      end
      chk($sformatf("u%0d ack c%0d", k, cyc), 32'(ack_o[k]), cyc == m_ack[k] ? 32'(1 << m_win[k]) : 0);
      chk($sformatf("u%0d err c%0d", k, cyc), 32'(err_o[k]), 32'(cyc == m_ack[k] && m_err[k]));
      chk($sformatf("u%0d cmd_vld c%0d", k, cyc), 32'(vld_o[k]), 32'(cyc == m_vld[k]));
      chk($sformatf("u%0d cmd_op c%0d", k, cyc), 32'(op_o[k]), 32'(m_op[k]));
      chk($sformatf("u%0d cmd_addr c%0d", k, cyc), 32'(addr_o[k]), 32'(m_addr[k]));
      chk($sformatf("u%0d cmd_data c%0d", k, cyc), data_o[k], m_data[k]);
      chk($sformatf("u%0d rdata c%0d", k, cyc), rdata_o[k], m_rdata[k]);
      if (reset_n) begin
        if (cyc == m_rd[k]) m_rdata[k] = core_rdata;
        if (cyc >= m_free[k] && req != 0) begin
          int w;
          w = -1;
          for (int i = 0; i < 4; i++) if (w < 0 && req[(m_ptr[k] + i) % 4]) w = (m_ptr[k] + i) % 4;
          m_win[k] = w;
          m_ptr[k] = (w + 1) % 4;
          m_op[k] = req_op[3*w +: 3];
          m_addr[k] = req_addr[4*w +: 4];
          m_data[k] = req_data[32*w +: 32];
          m_err[k] = !legal(m_op[k], m_addr[k]);
          m_vld[k] = m_err[k] ? -1 : cyc + 1;
          m_rd[k] = (!m_err[k] && m_op[k] == 3'd0) ? cyc + 1 + k : -1;
          m_ack[k] = m_err[k] ? cyc + 1 : cyc + 2 + (m_op[k] == 3'd0 ? k : 0);
          m_free[k] = m_ack[k] + 1;
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk_ug);
    #1;
  endtask
  task automatic setr(input int i, input logic [2:0] op, input logic [3:0] a, input logic [31:0] d);
    req[i] = 1'b1;
    req_op[3*i +: 3] = op;
    req_addr[4*i +: 4] = a;
    req_data[32*i +: 32] = d;
  endtask
  task automatic do_reset();
    step(1);
    reset_n = 1'b0;
    req = '0;
`ifdef EHL_GPIO_ARB_LOCK_EN
    req_lock = '0;
`endif
    step(2);
    reset_n = 1'b1;
  endtask
  task automatic pair(input int a, input logic [2:0] opa, input logic [3:0] aa,
                      input int b, input logic [2:0] opb, input logic [3:0] ab, input logic [31:0] core);
    logic [3:0] pend, got;
    step(1);
    core_rdata = core;
    setr(a, opa, aa, core ^ 32'(a));
    setr(b, opb, ab, ~core);
    pend = 4'(1 << a) | 4'(1 << b);
    for (int t = 0; t < 20 && pend != 0; t++) begin
      @(negedge clk_ug);
      got = ack_o[0] & pend;
      if (got != 0) begin
        pend &= ~got;
        step(1);
        req &= ~got;
      end
    end
    chk("pair completion", 32'(pend), 0);
    step(1);
    req = '0;
    step(3);
  endtask
  initial begin
    logic [3:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    @(negedge clk_ug);
    chk("reset ack", 32'(ack_o[0]), 0);
    chk("reset cmd_vld", 32'(vld_o[1]), 0);
    chk("reset rdata", rdata_o[1], 0);
    step(1);
    reset_n = 1'b1;
    // Single write from requester 1.
    step(1);
    setr(1, 3'd1, 4'd0, 32'hA5);
    @(negedge clk_ug);
    chk("wr c0 no strobe", 32'(vld_o[0]), 0);
    @(negedge clk_ug);
    chk("wr c1 cmd_vld", 32'(vld_o[0]), 1);
    chk("wr c1 cmd_addr", 32'(addr_o[0]), 0);
    chk("wr c1 cmd_data", data_o[0], 32'hA5);
    @(negedge clk_ug);
    chk("wr c2 ack", 32'(ack_o[0]), 32'b0010);
    chk("wr c2 err", 32'(err_o[0]), 0);
    step(1);
    req = '0;
    // Read of GDIR on both read latencies.
    step(1);
    core_rdata = 32'h1234;
    setr(0, 3'd0, 4'd8, 32'h0);
    repeat (3) @(negedge clk_ug);
    chk("rd lat0 ack c2", 32'(ack_o[0]), 32'b0001);
    chk("rd lat0 rdata", rdata_o[0], 32'h1234);
    chk("rd lat1 no ack c2", 32'(ack_o[1]), 0);
    step(1);
    req = '0;
    @(negedge clk_ug);
    chk("rd lat1 ack c3", 32'(ack_o[1]), 32'b0001);
    chk("rd lat1 rdata", rdata_o[1], 32'h1234);
    chk("rd lat1 cmd_op", 32'(op_o[1]), 0);
    chk("rd lat1 cmd_addr", 32'(addr_o[1]), 8);
    step(2);
    // Illegal: WRITE to GIFR, then op 5.
    step(1);
    setr(3, 3'd1, 4'd7, 32'hFF);
    @(negedge clk_ug);
    chk("ill gifr c0 no strobe", 32'(vld_o[0]), 0);
    @(negedge clk_ug);
    chk("ill gifr ack c1", 32'(ack_o[0]), 32'b1000);
    chk("ill gifr err c1", 32'(err_o[0]), 1);
    chk("ill gifr no strobe c1", 32'(vld_o[0]), 0);
    step(1);
    req = '0;
    step(1);
    setr(2, 3'd5, 4'd0, 32'h0);
    @(negedge clk_ug);
    @(negedge clk_ug);
    chk("ill op5 ack c1", 32'(ack_o[0]), 32'b0100);
    chk("ill op5 err c1", 32'(err_o[1]), 1);
    chk("ill op5 no strobe c1", 32'(vld_o[1]), 0);
    step(1);
    req = '0;
    // Reset while a command is in ISSUE, then a fresh grant from pointer 0.
    step(1);
    setr(2, 3'd1, 4'd1, 32'h55);
    @(negedge clk_ug);
    step(1);
    reset_n = 1'b0;
    req = '0;
    @(negedge clk_ug);
    chk("rst issue cmd_vld", 32'(vld_o[0]), 0);
    chk("rst issue cmd_data", data_o[0], 0);
    chk("rst issue rdata", rdata_o[0], 0);
    step(2);
    reset_n = 1'b1;
    step(1);
    setr(1, 3'd2, 4'd3, 32'h11);
    setr(3, 3'd3, 4'd6, 32'h33);
    repeat (3) @(negedge clk_ug);
    chk("post rst first grant", 32'(ack_o[0]), 32'b0010);
    step(1);
    req[1] = 1'b0;
    repeat (3) @(negedge clk_ug);
    chk("post rst second grant", 32'(ack_o[0]), 32'b1000);
    step(1);
    req = '0;
    // All four requesters held continuously from reset.
    do_reset();
    step(1);
    for (int i = 0; i < 4; i++) setr(i, 3'd1, 4'(i), 32'(i));
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_ug);
      if (c % 3 == 2) chk($sformatf("rr order %0d", c / 3), 32'(ack_o[0]), 32'(rr_exp[c / 3]));
    end
    step(1);
    req = '0;
    step(2);
    // Mixed legal/illegal pairs, checked by the model.
    pair(0, 3'd0, 4'd0, 2, 3'd1, 4'd1, 32'hDEADBEEF);
    pair(1, 3'd2, 4'd8, 3, 3'd3, 4'd7, 32'h00000001);
    pair(2, 3'd4, 4'd3, 0, 3'd0, 4'd6, 32'hCAFE0001);
    pair(3, 3'd0, 4'd11, 1, 3'd1, 4'd10, 32'h00000077);
    pair(0, 3'd7, 4'd2, 2, 3'd0, 4'd7, 32'h00008080);
    pair(1, 3'd4, 4'd8, 3, 3'd2, 4'd9, 32'h00000005);
`ifdef EHL_GPIO_ARB_LOCK_EN
    mdl_en = 1'b0;
    do_reset();
    step(1);
    setr(2, 3'd1, 4'd0, 32'h1);
    req_lock[2] = 1'b1;
    @(negedge clk_ug);
    step(1);
    setr(0, 3'd1, 4'd1, 32'h2);
    @(negedge clk_ug);
    @(negedge clk_ug);
    chk("lock first grant", 32'(ack_o[0]), 32'b0100);
    repeat (3) @(negedge clk_ug);
    chk("lock holder repeats", 32'(ack_o[0]), 32'b0100);
    step(1);
    req_lock[2] = 1'b0;
    repeat (3) @(negedge clk_ug);
    chk("lock released grant 0", 32'(ack_o[0]), 32'b0001);
    step(1);
    req = '0;
    do_reset();
    step(1);
    setr(2, 3'd1, 4'd0, 32'h1);
    req_lock[2] = 1'b1;
    repeat (3) @(negedge clk_ug);
    chk("tmo first grant", 32'(ack_o[0]), 32'b0100);
    step(1);
    req[2] = 1'b0;
    setr(0, 3'd1, 4'd1, 32'h2);
    repeat (6) @(negedge clk_ug);
    chk("tmo still blocked", 32'(ack_o[0]), 0);
    @(negedge clk_ug);
    chk("tmo forced release", 32'(ack_o[0]), 32'b0001);
    step(1);
    reset_n = 1'b0;
    req = '0;
    req_lock = '0;
    step(1);
    mdl_en = 1'b1;
    step(1);
    reset_n = 1'b1;
    pair(0, 3'd1, 4'd2, 3, 3'd0, 4'd4, 32'h0BADF00D);
`endif
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
